regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter NREGS, default 32, number of architectural registers (2..256).
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL derive localparam AW = clog2(NREGS), the register address width.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  input  1  reset: synchronous, active-low.
REQ-007 SHALL have port ra  input  NRD*AW  packed read addresses, port i at [i*AW +: AW].
REQ-008 SHALL have port rd  output  NRD*WIDTH  packed read data, port i at [i*WIDTH +: WIDTH].
REQ-009 SHALL have port rd_busy  output  NRD  per-port flag: addressed register has an outstanding load.
REQ-010 SHALL have port we  input  1  write enable.
REQ-011 SHALL have port wa  input  AW  write address.
REQ-012 SHALL have port wd  input  WIDTH  write data.
REQ-013 SHALL have port iss_valid  input  1  marks register iss_addr pending (load issued).
REQ-014 SHALL have port iss_addr  input  AW  destination register of the issued load.
REQ-015 SHALL have port pend_cnt  output  AW+1  number of currently pending registers.

Function
REQ-016 SHALL drive reads combinationally: rd[i] = register[ra[i]], with no clock latency.
REQ-017 SHALL return 0 on any read of address 0 or of an address >= NREGS.
REQ-018 SHALL write wd to register[wa] at a rising edge when reset=1, we=1, wa!=0 and wa<NREGS; in all other cases SHALL leave the register file unchanged.
REQ-019 SHALL keep one pending bit per register; bit 0 SHALL be constant 0.
REQ-020 SHALL set pending[iss_addr] at an edge when iss_valid=1, iss_addr!=0 and iss_addr<NREGS.
REQ-021 SHALL clear pending[wa] at an edge on any qualifying write (REQ-018).
REQ-022 If a set and a clear hit the same address in the same cycle, the set SHALL take priority; the bit SHALL end at 1.
REQ-023 Setting a bit that is already pending SHALL leave both the bit and pend_cnt unchanged.
REQ-024 SHALL drive rd_busy[i] = pending[ra[i]], subject to REQ-030.
REQ-025 SHALL register pend_cnt and update it incrementally in the same edge as the pending bits: +1 per 0->1 transition, -1 per 1->0 transition. A simultaneous set and clear on different addresses SHALL net to 0.
REQ-026 pend_cnt SHALL equal the popcount of the pending bits at all times; it SHALL never exceed NREGS-1 and SHALL never wrap.

Reset
REQ-027 At a rising edge with reset=0, SHALL clear all registers to 0, clear all pending bits, and set pend_cnt to 0.
REQ-028 Reset SHALL override any we or iss_valid presented in the same cycle.
REQ-029 After reset, all rd SHALL read 0 and all rd_busy SHALL be 0 from the first cycle onward.

Configuration
REQ-030 With REGFILE_BYPASS_EN defined:
- a qualifying write (REQ-018) with wa==ra[i] SHALL forward wd to rd[i] in the same cycle;
- rd_busy[i] SHALL be forced to 0 in that cycle, unless a same-cycle set (REQ-022) hits the same address.
REQ-031 Without REGFILE_BYPASS_EN, rd[i] SHALL show the pre-edge stored value, and rd_busy[i] SHALL show the pre-edge pending bit.

Structure
REQ-032 The following SHALL live in shared package mips_pkg:
- default constants for WIDTH, NREGS and NRD;
- a reg_addr_t typedef for AW-bit addresses.
REQ-033 The pending bits and pend_cnt SHALL be implemented in one sub-module, load_scoreboard, instantiated once; the storage array and read muxes SHALL stay in regfile_sb.

Verification
REQ-034 Reset and zero register:
- drive reset=0 for one cycle, then read all addresses -> every rd=0, rd_busy=0, pend_cnt=0;
- write wa=0, wd=0xDEADBEEF -> address 0 still reads 0.
REQ-035 Basic write/read: write wa=5, wd=0x12345678, then read ra[0]=5 and ra[1]=5 on the next cycle -> both ports return 0x12345678.
REQ-036 Pending set and clear:
- iss_valid with iss_addr=7 -> next cycle rd_busy=1 for ra=7 and pend_cnt=1;
- write wa=7 -> next cycle rd_busy=0 and pend_cnt=0.
REQ-037 Simultaneous events:
- same cycle: iss_addr=9 and write wa=9 -> pending[9]=1, pend_cnt +1;
- same cycle: iss_addr=3 and write to pending reg 4 -> pend_cnt unchanged.
REQ-038 Bypass (macro defined):
- write wa=10, wd=0xA5A5A5A5 with ra[0]=10 in the same cycle -> rd[0]=0xA5A5A5A5 and rd_busy[0]=0 in that cycle;
- without the macro -> rd[0] shows the old value.
REQ-039 Reset mid-operation: mark 3 registers pending, then assert reset=0 together with iss_valid=1 -> next cycle pend_cnt=0, all rd_busy=0, all rd=0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file constants and address type
package mips_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NRD   = 2;
    localparam int DEF_AW    = $clog2(DEF_NREGS);

    typedef logic [DEF_AW-1:0] reg_addr_t;

endpackage

// File: rtl/load_scoreboard.sv
// rtl/load_scoreboard.sv - per-register pending bits with an incrementally kept pending count
module load_scoreboard
    import mips_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [AW-1:0]    set_addr,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_addr,
    output logic [NREGS-1:0] pending,
    output logic [AW:0]      pend_cnt
);

    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] pending_nxt;
    logic             inc;
    logic             dec;

    // Decode set/clear into one-hot vectors; a set wins over a clear on the same bit,
    // and the count only moves on real 0->1 / 1->0 transitions.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int j = 1; j < NREGS; j++) begin
            set_vec[j] = set_en && (set_addr == AW'(j));
            clr_vec[j] = clr_en && (clr_addr == AW'(j));
        end
        pending_nxt    = set_vec | (pending & ~clr_vec);
        pending_nxt[0] = 1'b0;
        inc            = |(set_vec & ~pending);
        dec            = |(clr_vec & pending & ~set_vec);
    end

    // Pending bits and count advance together so the count always equals the popcount.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pending_nxt;
            pend_cnt <= pend_cnt + (AW+1)'(inc) - (AW+1)'(dec);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with combinational reads and load scoreboard; optional REGFILE_BYPASS_EN write forwarding
module regfile_sb
    import mips_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = DEF_NRD,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NRD*AW-1:0]  ra,
    output logic [NRD*WIDTH-1:0] rd,
    output logic [NRD-1:0]     rd_busy,
    input  logic               we,
    input  logic [AW-1:0]      wa,
    input  logic [WIDTH-1:0]   wd,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_addr,
    output logic [AW:0]        pend_cnt
);

    logic [WIDTH-1:0] mem [NREGS];
    logic [NREGS-1:0] pending;
    logic             wr_ok;
    logic             iss_ok;

    // Register 0 and out-of-range addresses are never written nor marked pending.
    always_comb begin
        wr_ok  = reset && we && (wa != '0) && (32'(wa) < 32'(NREGS));
        iss_ok = reset && iss_valid && (iss_addr != '0) && (32'(iss_addr) < 32'(NREGS));
    end

    // Storage array: reset clears every entry, otherwise one qualifying write per edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int j = 0; j < NREGS; j++) begin
                mem[j] <= '0;
            end
        end else if (wr_ok) begin
            mem[wa] <= wd;
        end
    end

    load_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (iss_ok),
        .set_addr (iss_addr),
        .clr_en   (wr_ok),
        .clr_addr (wa),
        .pending  (pending),
        .pend_cnt (pend_cnt)
    );

    // Read muxes: address 0 and out-of-range addresses read as zero and never busy.
    always_comb begin
        rd      = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            logic [AW-1:0] a;
            logic          in_rng;
            a      = ra[i*AW +: AW];
            in_rng = (a != '0) && (32'(a) < 32'(NREGS));
            if (in_rng) begin
                rd[i*WIDTH +: WIDTH] = mem[a];
                rd_busy[i]           = pending[a];
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wa == a)) begin
                rd[i*WIDTH +: WIDTH] = wd;
                rd_busy[i]           = iss_ok && (iss_addr == a);
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard-checked directed bench for regfile_sb
module tb_regfile_sb;
    import mips_pkg::*;

    localparam int AW = DEF_AW;

    typedef struct {
        string       name;
        int          kind;   // 0 rd0, 1 rd1, 2 busy0, 3 busy1, 4 pend_cnt
        logic [31:0] value;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [2*AW-1:0] ra;
    logic [63:0]     rd;
    logic [1:0]      rd_busy;
    logic            we;
    reg_addr_t       wa;
    logic [31:0]     wd;
    logic            iss_valid;
    reg_addr_t       iss_addr;
    logic [AW:0]     pend_cnt;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    regfile_sb dut (
        .clk       (clk),
        .reset     (reset),
        .ra        (ra),
        .rd        (rd),
        .rd_busy   (rd_busy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .pend_cnt  (pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        we        = 1'b0;
        iss_valid = 1'b0;
        reset     = 1'b1;
    endtask

    task automatic set_ra(input int a0, input int a1);
        ra = {AW'(a1), AW'(a0)};
    endtask

    task automatic expect_v(input string name, input int kind, input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.kind  = kind;
        e.value = value;
        q.push_back(e);
    endtask

    // Monitor: outputs are settled at the falling edge; compare every queued expectation.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.kind)
                0:       act = rd[31:0];
                1:       act = rd[63:32];
                2:       act = {31'b0, rd_busy[0]};
                3:       act = {31'b0, rd_busy[1]};
                default: act = 32'(pend_cnt);
            endcase
            n_checks++;
            if (act === e.value) n_pass++;
            else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.value);
        end
    end

    initial begin
        reset = 1'b0; we = 1'b0; wa = '0; wd = '0;
        iss_valid = 1'b0; iss_addr = '0; ra = '0;
        @(posedge clk); #1;
        reset = 1'b1;

        // Reset state over every address
        for (int a = 0; a < 32; a++) begin
            set_ra(a, 31 - a);
            expect_v("rst_rd0", 0, 32'h0);
            expect_v("rst_rd1", 1, 32'h0);
            expect_v("rst_busy0", 2, 32'h0);
            expect_v("rst_busy1", 3, 32'h0);
            expect_v("rst_cnt", 4, 32'h0);
            tick();
        end

        // Write to register 0 is ignored
        we = 1'b1; wa = 0; wd = 32'hDEADBEEF; set_ra(1, 2);
        tick();
        set_ra(0, 0);
        expect_v("zero_rd0", 0, 32'h0);
        expect_v("zero_cnt", 4, 32'h0);

        // Basic write/read on both ports
        we = 1'b1; wa = 5; wd = 32'h12345678;
        tick();
        set_ra(5, 5);
        expect_v("wr5_rd0", 0, 32'h12345678);
        expect_v("wr5_rd1", 1, 32'h12345678);

        // Pending set then clear by write
        iss_valid = 1'b1; iss_addr = 7;
        tick();
        set_ra(7, 5);
        expect_v("iss7_busy0", 2, 32'h1);
        expect_v("iss7_busy1", 3, 32'h0);
        expect_v("iss7_cnt", 4, 32'h1);
        we = 1'b1; wa = 7; wd = 32'h00000077;
        tick();
        expect_v("wr7_busy0", 2, 32'h0);
        expect_v("wr7_cnt", 4, 32'h0);
        expect_v("wr7_rd0", 0, 32'h00000077);

        // Same-address set and clear: set wins
        iss_valid = 1'b1; iss_addr = 9; we = 1'b1; wa = 9; wd = 32'h00000099;
        tick();
        set_ra(9, 0);
        expect_v("sc9_busy0", 2, 32'h1);
        expect_v("sc9_cnt", 4, 32'h1);
        expect_v("sc9_rd0", 0, 32'h00000099);

        // Re-setting a pending bit leaves count unchanged
        iss_valid = 1'b1; iss_addr = 9;
        tick();
        expect_v("reiss9_cnt", 4, 32'h1);

        // Set 3 and clear pending 4 in one cycle: count nets to zero change
        iss_valid = 1'b1; iss_addr = 4;
        tick();
        expect_v("iss4_cnt", 4, 32'h2);
        iss_valid = 1'b1; iss_addr = 3; we = 1'b1; wa = 4; wd = 32'h00000044;
        tick();
        set_ra(3, 4);
        expect_v("sc34_cnt", 4, 32'h2);
        expect_v("sc34_busy3", 2, 32'h1);
        expect_v("sc34_busy4", 3, 32'h0);
        expect_v("sc34_rd4", 1, 32'h00000044);

        // Write-to-read same cycle on a pending register
        iss_valid = 1'b1; iss_addr = 10; we = 1'b1; wa = 10; wd = 32'h00001111;
        tick();
        expect_v("pre10_cnt", 4, 32'h3);
        we = 1'b1; wa = 10; wd = 32'hA5A5A5A5; set_ra(10, 9);
`ifdef REGFILE_BYPASS_EN
        expect_v("byp_rd0", 0, 32'hA5A5A5A5);
        expect_v("byp_busy0", 2, 32'h0);
`else
        expect_v("nobyp_rd0", 0, 32'h00001111);
        expect_v("nobyp_busy0", 2, 32'h1);
`endif
        expect_v("byp_rd1", 1, 32'h00000099);
        expect_v("byp_cnt", 4, 32'h3);
        tick();
        expect_v("post10_rd0", 0, 32'hA5A5A5A5);
        expect_v("post10_busy0", 2, 32'h0);
        expect_v("post10_cnt", 4, 32'h2);

        // Out-of-range-free boundary: address 31 write/read
        we = 1'b1; wa = 31; wd = 32'hCAFEF00D;
        tick();
        set_ra(31, 0);
        expect_v("wr31_rd0", 0, 32'hCAFEF00D);
        expect_v("wr31_rd1", 1, 32'h0);

        // Three pending, then reset with simultaneous issue and write
        iss_valid = 1'b1; iss_addr = 12;
        tick();
        expect_v("iss12_cnt", 4, 32'h3);
        tick();
        reset = 1'b0; iss_valid = 1'b1; iss_addr = 15; we = 1'b1; wa = 20; wd = 32'h0BADF00D;
        @(posedge clk); #1;
        reset = 1'b1; iss_valid = 1'b0; we = 1'b0;
        set_ra(9, 5);
        expect_v("mrst_cnt", 4, 32'h0);
        expect_v("mrst_busy0", 2, 32'h0);
        expect_v("mrst_busy1", 3, 32'h0);
        expect_v("mrst_rd0", 0, 32'h0);
        expect_v("mrst_rd1", 1, 32'h0);
        tick();
        set_ra(15, 20);
        expect_v("mrst_busy15", 2, 32'h0);
        expect_v("mrst_rd20", 1, 32'h0);
        tick();
        set_ra(12, 31);
        expect_v("mrst_busy12", 2, 32'h0);
        expect_v("mrst_rd31", 1, 32'h0);
        tick();
        tick();

        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d queued expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
